mem_line_ctrl: RTL

Line-transfer controller between the data cache and the word-wide simulated main memory. On a cache miss it writes back a dirty victim line, then fills the new line, one word per memory handshake. It drives the memory's `re`/`we`/`a`/`wd` and consumes `rd`/`Valid`. Cache-side words are written into the line buffer as they arrive, and completion is reported with a one-cycle `done` pulse.

---
 rtl/mem_line_ctrl_if.sv | 20 ++
 rtl/mem_line_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_line_ctrl_if.sv
// Word-wide memory port: request/address/write-data toward memory, read-data and
// a one-cycle completion pulse back from it.
interface mem_line_ctrl_if;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_valid;

  modport master (
    output mem_re, mem_we, mem_a, mem_wd,
    input  mem_rd, mem_valid
  );

  modport slave (
    input  mem_re, mem_we, mem_a, mem_wd,
    output mem_rd, mem_valid
  );
endinterface

// File: rtl/mem_line_ctrl.sv
// Cache miss line mover: optional dirty-victim writeback, then fill, one word per memory handshake.
// Request, address and data are held until mem_valid; done pulses one cycle after the last fill word.
module mem_line_ctrl #(
  parameter  int blocksize = 4,
  localparam int IB        = $clog2(blocksize)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          dirty,
  input  logic [31:0]   wb_addr,
  input  logic [31:0]   fill_addr,
  input  logic [31:0]   wb_word,
  output logic [IB-1:0] word_idx,
  output logic          fill_we,
  output logic [31:0]   fill_data,
  output logic          busy,
  output logic          done,
  mem_line_ctrl_if.master mem
);

  localparam int BW = 32 - IB - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IB-1:0] idx_q, idx_d;
  logic [BW-1:0] wb_base_q, wb_base_d;
  logic [BW-1:0] fill_base_q, fill_base_d;
  logic          last_word;

  // Word-offset bits of the line addresses are implied by idx.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wb_addr[IB+1:0], fill_addr[IB+1:0]};

  assign last_word = (idx_q == IB'(blocksize - 1));
  assign word_idx  = idx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wb_base_q   <= '0;
      fill_base_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wb_base_q   <= wb_base_d;
      fill_base_q <= fill_base_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wb_base_d   = wb_base_q;
    fill_base_d = fill_base_q;
    mem.mem_re  = 1'b0;
    mem.mem_we  = 1'b0;
    mem.mem_a   = '0;
    mem.mem_wd  = '0;
    fill_we     = 1'b0;
    fill_data   = mem.mem_rd;
    done        = 1'b0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          wb_base_d   = wb_addr[31:IB+2];
          fill_base_d = fill_addr[31:IB+2];
          idx_d       = '0;
          state_d     = dirty ? WB : FILL;
        end
      end

      WB: begin
        mem.mem_we = 1'b1;
        mem.mem_a  = {wb_base_q, idx_q, 2'b00};
        mem.mem_wd = wb_word;
        if (mem.mem_valid) begin
          idx_d = last_word ? '0 : idx_q + IB'(1);
          if (last_word) state_d = FILL;
        end
      end

      FILL: begin
        mem.mem_re = 1'b1;
        mem.mem_a  = {fill_base_q, idx_q, 2'b00};
        fill_we    = mem.mem_valid;
        if (mem.mem_valid) begin
          idx_d = last_word ? '0 : idx_q + IB'(1);
          if (last_word) state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
